stage1_operand_latch: RTL and testbench
=======================================

Name: stage1_operand_latch

Overview:
- Stage-1 → stage-2 pipeline register of the 3-stage RISC-V core; sits directly downstream of RegFile.
- Decodes register fields from the fetched instruction and drives RegFile read addresses.
- Captures RegFile read data with writeback bypass applied, and registers PC, instruction and destination register.
- Produces per-operand EX-forward flags for stage 2; handles stall (hold) and flush (bubble).

Parameters:
XLEN, 32, datapath width
NOP, 32'h0000_0013, instruction loaded on bubble/reset (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-low; asserted when 0 at posedge
stall  in  1  hold all stage-2 registers
flush  in  1  replace stage-2 contents with bubble
inst_in  in  32  instruction from fetch
pc_in  in  32  PC of inst_in
inst_valid_in  in  1  inst_in is valid
rs1  out  5  RegFile read address, = inst_in[19:15], combinational
rs2  out  5  RegFile read address, = inst_in[24:20], combinational
rs1d  in  32  RegFile read data 1
rs2d  in  32  RegFile read data 2
wb_rd  in  5  writeback destination (same signal fed to RegFile rd)
wb_data  in  32  writeback data
wb_we  in  1  writeback enable
ex_valid  out  1  stage-2 instruction valid
ex_pc  out  32  stage-2 PC
ex_inst  out  32  stage-2 instruction
ex_rs1d  out  32  operand 1
ex_rs2d  out  32  operand 2
ex_rd  out  5  destination; 0 if the instruction does not write rd
ex_fwd1  out  1  operand 1 must come from the older instruction's stage-2 result
ex_fwd2  out  1  operand 2, same meaning

Behaviour:
- Decode (combinational, on inst_in opcode):
  - writes_rd: LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, SYSTEM with funct3≠0.
  - uses_rs1: all except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
  - Unknown opcode: none of the three.
- Bypass value N:
  - 0 if rsN==0.
  - Else wb_data if wb_we && wb_rd==rsN.
  - Else rsNd.
  - wb_rd==0 never bypasses.
- Priority at posedge: reset > flush > stall > advance.
- Reset (reset==0):
  - ex_valid=0, ex_inst=NOP, ex_pc=0, ex_rs1d=0, ex_rs2d=0, ex_rd=0, ex_fwd1=0, ex_fwd2=0.
  - Overrides stall and flush, including mid-stall.
- Flush: same values as reset.
- Stall:
  - All outputs hold.
  - Exception: if wb_we && wb_rd≠0 && wb_rd equals the held instruction's rs1 field (rs2 field) and that operand is used, ex_rs1d (ex_rs2d) <= wb_data. This prevents a stale held operand.
  - fwd flags hold.
- Advance, inst_valid_in=1:
  - ex_valid=1, ex_pc=pc_in, ex_inst=inst_in.
  - ex_rd = writes_rd ? inst_in[11:7] : 0.
  - ex_rsNd = bypass value N.
  - ex_fwdN = uses_rsN && rsN≠0 && ex_valid && rsN==ex_rd, using current (pre-update) ex_valid and ex_rd.
- Advance, inst_valid_in=0: bubble, same values as flush.
- When a fwd flag and a wb bypass both match the same register: both are applied. Stage 2 gives ex_fwdN priority, since it represents the younger producer.
- Latency: one cycle from inst_in to ex_*. rs1/rs2 are zero-latency.
- No X on outputs after the first reset cycle. Outputs are undefined only before the first reset.

Decomposition:
- Package rv_pkg:
  - Opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM.
  - INST_NOP.
  - Field-slice constants.
- Sub-module reg_use_decode: combinational; inst → writes_rd, uses_rs1, uses_rs2. Reused later by stage-2 hazard logic.
- Bypass muxes and pipeline registers live in the top block.

Test Plan:
1. Reset:
   - Stimulus: reset=0 for 2 cycles with inst_valid_in=1, inst_in=0x002081B3, stall=1.
   - Response: ex_valid=0, ex_inst=0x00000013, ex_rs1d=ex_rs2d=0, ex_rd=0, fwd=0.
2. WB bypass and x0:
   - Stimulus: inst_in=0x002081B3 (add x3,x1,x2), rs1d=0x11, rs2d=0x22, wb_we=1, wb_rd=1, wb_data=0xDEADBEEF.
   - Response: ex_rs1d=0xDEADBEEF, ex_rs2d=0x22, ex_rd=3.
   - Then with inst_in=0x00000093 (addi x1,x0,0), rs1d=0xFFFF, wb_rd=0: ex_rs1d=0.
3. EX forward:
   - Stimulus: addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333).
   - Response: second cycle ex_fwd1=ex_fwd2=1.
   - Then sw x6,0(x5) (0x0062A023) with ex_rd of the prior add=6: ex_fwd2=1, ex_fwd1=0, ex_rd=0.
   - Then add x7,x6,x0 (0x000303B3): ex_fwd1=0, because the store has ex_rd=0.
4. Stall refresh:
   - Stimulus: add x3,x1,x2 captured; next cycle stall=1, wb_we=1, wb_rd=2, wb_data=0x1234, new inst_in=0x00100293.
   - Response: ex_rs2d=0x1234; ex_rs1d, ex_pc, ex_inst, ex_rd unchanged.
5. Priorities:
   - flush=1 with stall=1 → bubble.
   - reset=0 with flush=0, stall=1 → reset values.
   - inst_valid_in=0 while advancing → ex_valid=0, ex_inst=NOP.
6. Unused operand:
   - Stimulus: lui x1,0x12345 (0x123450B7) with rs1d=0xAAAA, wb_rd=matching rs1 field.
   - Response: ex_fwd1=0, ex_rd=1.
   - Operand value is don't-care, but the bench checks only the defined fields.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: major opcodes, the canonical NOP, and the
// bit positions of the register fields in an instruction word.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int OPC_LSB    = 0;
    localparam int OPC_MSB    = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/reg_use_decode.sv
// Register-usage decode: from opcode and funct3, which of rd/rs1/rs2 the
// instruction actually writes or reads. Unknown opcodes use none of them.
module reg_use_decode
    import rv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output logic       o_writes_rd,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2
);

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        o_writes_rd = 1'b0;
        o_uses_rs1  = 1'b0;
        o_uses_rs2  = 1'b0;
        case (i_opcode)
            OPC_LUI,
            OPC_AUIPC,
            OPC_JAL: begin
                o_writes_rd = 1'b1;
            end
            OPC_JALR,
            OPC_OPIMM,
            OPC_LOAD: begin
                o_writes_rd = 1'b1;
                o_uses_rs1  = 1'b1;
            end
            OPC_OP: begin
                o_writes_rd = 1'b1;
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
            end
            OPC_STORE,
            OPC_BRANCH: begin
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK/MRET share funct3 == 0 and write nothing.
                o_writes_rd = (i_funct3 != 3'b000);
                o_uses_rs1  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/stage1_operand_latch.sv
// Stage-1 -> stage-2 pipeline register: drives RegFile read addresses, latches
// bypassed operands, PC, instruction and rd, and flags EX-stage forwarding.
module stage1_operand_latch
    import rv_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = INST_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            inst_valid_in,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] rs1d,
    input  logic [XLEN-1:0] rs2d,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_we,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_inst,
    output logic [XLEN-1:0] ex_rs1d,
    output logic [XLEN-1:0] ex_rs2d,
    output logic [4:0]      ex_rd,
    output logic            ex_fwd1,
    output logic            ex_fwd2
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_rs1d;
    logic [XLEN-1:0] r_rs2d;
    logic [4:0]      r_rd;
    logic            r_fwd1;
    logic            r_fwd2;

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd_field;
    logic            w_writes_rd;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic [XLEN-1:0] w_byp1;
    logic [XLEN-1:0] w_byp2;
    logic            w_fwd1;
    logic            w_fwd2;

    logic [4:0]      w_held_rs1;
    logic [4:0]      w_held_rs2;
    logic            w_held_writes_rd;
    logic            w_held_uses_rs1;
    logic            w_held_uses_rs2;
    logic            w_wb_live;
    logic            w_refresh1;
    logic            w_refresh2;
    logic            w_bubble;

    assign w_rs1      = inst_in[RS1_MSB:RS1_LSB];
    assign w_rs2      = inst_in[RS2_MSB:RS2_LSB];
    assign w_rd_field = inst_in[RD_MSB:RD_LSB];
    assign rs1        = w_rs1;
    assign rs2        = w_rs2;

    reg_use_decode u_in_decode (
        .i_opcode    (inst_in[OPC_MSB:OPC_LSB]),
        .i_funct3    (inst_in[FUNCT3_MSB:FUNCT3_LSB]),
        .o_writes_rd (w_writes_rd),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2)
    );

    // Second decoder on the held instruction: a stalled operand is refreshed
    // from writeback only if that instruction really reads the register.
    reg_use_decode u_held_decode (
        .i_opcode    (r_inst[OPC_MSB:OPC_LSB]),
        .i_funct3    (r_inst[FUNCT3_MSB:FUNCT3_LSB]),
        .o_writes_rd (w_held_writes_rd),
        .o_uses_rs1  (w_held_uses_rs1),
        .o_uses_rs2  (w_held_uses_rs2)
    );

    assign w_held_rs1 = r_inst[RS1_MSB:RS1_LSB];
    assign w_held_rs2 = r_inst[RS2_MSB:RS2_LSB];
    assign w_wb_live  = wb_we && (wb_rd != REG_X0);

    // RegFile reads lag a same-cycle write, so writeback data is bypassed.
    always_comb begin
        w_byp1 = rs1d;
        if (w_rs1 == REG_X0) begin
            w_byp1 = '0;
        end else if (w_wb_live && (wb_rd == w_rs1)) begin
            w_byp1 = wb_data;
        end
    end

    always_comb begin
        w_byp2 = rs2d;
        if (w_rs2 == REG_X0) begin
            w_byp2 = '0;
        end else if (w_wb_live && (wb_rd == w_rs2)) begin
            w_byp2 = wb_data;
        end
    end

    // r_rd is already 0 for bubbles and non-writers, so r_valid is belt and braces.
    assign w_fwd1 = w_uses_rs1 && (w_rs1 != REG_X0) && r_valid && (w_rs1 == r_rd);
    assign w_fwd2 = w_uses_rs2 && (w_rs2 != REG_X0) && r_valid && (w_rs2 == r_rd);

    assign w_refresh1 = w_wb_live && w_held_uses_rs1 && (wb_rd == w_held_rs1);
    assign w_refresh2 = w_wb_live && w_held_uses_rs2 && (wb_rd == w_held_rs2);

    // Reset, flush and an invalid advancing slot all load the same bubble.
    assign w_bubble = !reset || flush || (!stall && !inst_valid_in);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= NOP;
            r_rs1d  <= '0;
            r_rs2d  <= '0;
            r_rd    <= REG_X0;
            r_fwd1  <= 1'b0;
            r_fwd2  <= 1'b0;
        end else if (stall) begin
            if (w_refresh1) begin
                r_rs1d <= wb_data;
            end
            if (w_refresh2) begin
                r_rs2d <= wb_data;
            end
        end else begin
            r_valid <= 1'b1;
            r_pc    <= pc_in;
            r_inst  <= inst_in;
            r_rs1d  <= w_byp1;
            r_rs2d  <= w_byp2;
            r_rd    <= w_writes_rd ? w_rd_field : REG_X0;
            r_fwd1  <= w_fwd1;
            r_fwd2  <= w_fwd2;
        end
    end

    assign ex_valid = r_valid;
    assign ex_pc    = r_pc;
    assign ex_inst  = r_inst;
    assign ex_rs1d  = r_rs1d;
    assign ex_rs2d  = r_rs2d;
    assign ex_rd    = r_rd;
    assign ex_fwd1  = r_fwd1;
    assign ex_fwd2  = r_fwd2;

endmodule

// File: tb/tb_stage1_operand_latch.sv
// Scoreboard bench for stage1_operand_latch: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_stage1_operand_latch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        inst_valid_in;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_rs1d;
    logic [31:0] ex_rs2d;
    logic [4:0]  ex_rd;
    logic        ex_fwd1;
    logic        ex_fwd2;

    stage1_operand_latch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .inst_in       (inst_in),
        .pc_in         (pc_in),
        .inst_valid_in (inst_valid_in),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1d          (rs1d),
        .rs2d          (rs2d),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_we         (wb_we),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_inst       (ex_inst),
        .ex_rs1d       (ex_rs1d),
        .ex_rs2d       (ex_rs2d),
        .ex_rd         (ex_rd),
        .ex_fwd1       (ex_fwd1),
        .ex_fwd2       (ex_fwd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        f1;
        logic        f2;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        chk_ops;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_steps  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp_v);
        end
    endtask

    function automatic exp_t ex(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                                input logic f1, input logic f2, input logic [4:0] a1,
                                input logic [4:0] a2, input logic chk_ops);
        exp_t e;
        e.id = 0; e.valid = v; e.pc = pc; e.inst = inst; e.d1 = d1; e.d2 = d2;
        e.rd = rd; e.f1 = f1; e.f2 = f2; e.a1 = a1; e.a2 = a2; e.chk_ops = chk_ops;
        return e;
    endfunction

    function automatic exp_t bub(input logic [4:0] a1, input logic [4:0] a2);
        return ex(1'b0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, a1, a2, 1'b1);
    endfunction

    task automatic drive(input logic rst_v, input logic stall_v, input logic flush_v,
                         input logic valid_v, input logic [31:0] inst_v, input logic [31:0] pc_v,
                         input logic [31:0] d1, input logic [31:0] d2, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wdata);
        reset = rst_v; stall = stall_v; flush = flush_v; inst_valid_in = valid_v;
        inst_in = inst_v; pc_in = pc_v; rs1d = d1; rs2d = d2;
        wb_we = we; wb_rd = wrd; wb_data = wdata;
    endtask

    // One clock: the expectation describes outputs after this posedge.
    task automatic step(input exp_t e);
        exp_t t;
        t = e;
        t.id = n_steps;
        n_steps++;
        @(posedge clk);
        sb_q.push_back(t);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("s%0d.ex_valid", mon_e.id), {31'b0, ex_valid}, {31'b0, mon_e.valid});
            check($sformatf("s%0d.ex_pc", mon_e.id), ex_pc, mon_e.pc);
            check($sformatf("s%0d.ex_inst", mon_e.id), ex_inst, mon_e.inst);
            if (mon_e.chk_ops) begin
                check($sformatf("s%0d.ex_rs1d", mon_e.id), ex_rs1d, mon_e.d1);
                check($sformatf("s%0d.ex_rs2d", mon_e.id), ex_rs2d, mon_e.d2);
            end
            check($sformatf("s%0d.ex_rd", mon_e.id), {27'b0, ex_rd}, {27'b0, mon_e.rd});
            check($sformatf("s%0d.ex_fwd1", mon_e.id), {31'b0, ex_fwd1}, {31'b0, mon_e.f1});
            check($sformatf("s%0d.ex_fwd2", mon_e.id), {31'b0, ex_fwd2}, {31'b0, mon_e.f2});
            check($sformatf("s%0d.rs1", mon_e.id), {27'b0, rs1}, {27'b0, mon_e.a1});
            check($sformatf("s%0d.rs2", mon_e.id), {27'b0, rs2}, {27'b0, mon_e.a2});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two cycles with a valid instruction and stall asserted.
        drive(0, 1, 0, 1, 32'h002081B3, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        step(bub(5'd1, 5'd2));
        step(bub(5'd1, 5'd2));

        // add x3,x1,x2 with writeback bypass on x1.
        drive(1, 0, 0, 1, 32'h002081B3, 32'h100, 32'h11, 32'h22, 1, 5'd1, 32'hDEADBEEF);
        step(ex(1, 32'h100, 32'h002081B3, 32'hDEADBEEF, 32'h22, 5'd3, 0, 0, 5'd1, 5'd2, 1));
        // addi x1,x0,0: x0 reads as zero; wb_rd = 0 never bypasses.
        drive(1, 0, 0, 1, 32'h00000093, 32'h104, 32'hFFFF, 32'h5555, 1, 5'd0, 32'hDEADBEEF);
        step(ex(1, 32'h104, 32'h00000093, 32'h0, 32'h0, 5'd1, 0, 0, 5'd0, 5'd0, 1));

        // addi x5,x0,1: rs2 field = 1 matches ex_rd but is unused, no fwd2.
        drive(1, 0, 0, 1, 32'h00100293, 32'h200, 32'h77, 32'h88, 0, 5'd0, 32'h0);
        step(ex(1, 32'h200, 32'h00100293, 32'h0, 32'h88, 5'd5, 0, 0, 5'd0, 5'd1, 1));
        // add x6,x5,x5: both operands forwarded from EX.
        drive(1, 0, 0, 1, 32'h00528333, 32'h204, 32'h50, 32'h51, 0, 5'd0, 32'h0);
        step(ex(1, 32'h204, 32'h00528333, 32'h50, 32'h51, 5'd6, 1, 1, 5'd5, 5'd5, 1));
        // Stall: flags hold, both held operands (x5) refreshed from writeback.
        drive(1, 1, 0, 1, 32'h0062A023, 32'h208, 32'h60, 32'h61, 1, 5'd5, 32'h5555);
        step(ex(1, 32'h204, 32'h00528333, 32'h5555, 32'h5555, 5'd6, 1, 1, 5'd5, 5'd6, 1));
        // sw x6,0(x5): fwd2 and wb bypass on x6 both applied; store has rd 0.
        drive(1, 0, 0, 1, 32'h0062A023, 32'h208, 32'h60, 32'h61, 1, 5'd6, 32'hCAFE);
        step(ex(1, 32'h208, 32'h0062A023, 32'h60, 32'hCAFE, 5'd0, 0, 1, 5'd5, 5'd6, 1));
        // add x7,x6,x0: store ahead has ex_rd 0, so no forwarding.
        drive(1, 0, 0, 1, 32'h000303B3, 32'h20C, 32'h70, 32'h71, 0, 5'd0, 32'h0);
        step(ex(1, 32'h20C, 32'h000303B3, 32'h70, 32'h0, 5'd7, 0, 0, 5'd6, 5'd0, 1));

        // Stall refresh of operand 2 only.
        drive(1, 0, 0, 1, 32'h002081B3, 32'h300, 32'hA1, 32'hA2, 0, 5'd0, 32'h0);
        step(ex(1, 32'h300, 32'h002081B3, 32'hA1, 32'hA2, 5'd3, 0, 0, 5'd1, 5'd2, 1));
        drive(1, 1, 0, 1, 32'h00100293, 32'h304, 32'hB1, 32'hB2, 1, 5'd2, 32'h1234);
        step(ex(1, 32'h300, 32'h002081B3, 32'hA1, 32'h1234, 5'd3, 0, 0, 5'd0, 5'd1, 1));
        // Writeback to the held rd (not a source) changes nothing.
        drive(1, 1, 0, 1, 32'h00100293, 32'h304, 32'hB1, 32'hB2, 1, 5'd3, 32'h9999);
        step(ex(1, 32'h300, 32'h002081B3, 32'hA1, 32'h1234, 5'd3, 0, 0, 5'd0, 5'd1, 1));

        // Priorities: flush beats stall; reset beats stall; invalid advance bubbles.
        drive(1, 1, 1, 1, 32'h00100293, 32'h304, 32'hB1, 32'hB2, 0, 5'd0, 32'h0);
        step(bub(5'd0, 5'd1));
        drive(1, 0, 0, 1, 32'h002081B3, 32'h400, 32'h1, 32'h2, 0, 5'd0, 32'h0);
        step(ex(1, 32'h400, 32'h002081B3, 32'h1, 32'h2, 5'd3, 0, 0, 5'd1, 5'd2, 1));
        drive(0, 1, 0, 1, 32'h002081B3, 32'h404, 32'h1, 32'h2, 0, 5'd0, 32'h0);
        step(bub(5'd1, 5'd2));
        drive(1, 0, 0, 1, 32'h002081B3, 32'h500, 32'h3, 32'h4, 0, 5'd0, 32'h0);
        step(ex(1, 32'h500, 32'h002081B3, 32'h3, 32'h4, 5'd3, 0, 0, 5'd1, 5'd2, 1));
        drive(1, 0, 0, 0, 32'h002081B3, 32'h504, 32'h3, 32'h4, 0, 5'd0, 32'h0);
        step(bub(5'd1, 5'd2));

        // lui x1: rs1 field (x8) matches ex_rd but is unused -> no fwd1.
        drive(1, 0, 0, 1, 32'h00208433, 32'h600, 32'h5, 32'h6, 0, 5'd0, 32'h0);
        step(ex(1, 32'h600, 32'h00208433, 32'h5, 32'h6, 5'd8, 0, 0, 5'd1, 5'd2, 1));
        drive(1, 0, 0, 1, 32'h123450B7, 32'h604, 32'hAAAA, 32'hBBBB, 1, 5'd8, 32'hBBBB);
        step(ex(1, 32'h604, 32'h123450B7, 32'h0, 32'h0, 5'd1, 0, 0, 5'd8, 5'd3, 0));

        // SYSTEM: ecall writes nothing, csrrs x9 writes rd; unknown opcode writes nothing.
        drive(1, 0, 0, 1, 32'h00000073, 32'h608, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        step(ex(1, 32'h608, 32'h00000073, 32'h0, 32'h0, 5'd0, 0, 0, 5'd0, 5'd0, 1));
        drive(1, 0, 0, 1, 32'h300024F3, 32'h60C, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        step(ex(1, 32'h60C, 32'h300024F3, 32'h0, 32'h0, 5'd9, 0, 0, 5'd0, 5'd0, 1));
        drive(1, 0, 0, 1, 32'h002081FF, 32'h610, 32'h31, 32'h32, 0, 5'd0, 32'h0);
        step(ex(1, 32'h610, 32'h002081FF, 32'h31, 32'h32, 5'd0, 0, 0, 5'd1, 5'd2, 1));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
